// File: rtl/vend_fsm_param.sv
// Parameterised vending controller: accumulates one-hot coins into credit, dispenses
// one product per request and returns any remainder as a one-cycle change strobe.
module vend_fsm_param #(
  parameter int NPROD    = 4,
  parameter int NCOIN    = 3,
  parameter int CREDIT_W = 6,
  parameter logic [NPROD*CREDIT_W-1:0] PRICES    = {6'd9, 6'd7, 6'd5, 6'd3},
  parameter logic [NCOIN*CREDIT_W-1:0] COIN_VALS = {6'd5, 6'd2, 6'd1}
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NCOIN-1:0]    coin_i,
  input  logic [NPROD-1:0]    sel_i,
  input  logic                cancel_i,
  output logic [NPROD-1:0]    dispense_o,
  output logic [CREDIT_W-1:0] change_val_o,
  output logic                change_vld_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                coin_rej_o,
  output logic [2:0]          status_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

  localparam int ERR = 2, SHORT = 1, OK = 0;

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q, change_val_q;
  logic [NPROD-1:0]    dispense_q;
  logic                change_vld_q, coin_rej_q;
  logic [2:0]          status_q;

  logic                coin_one, coin_any, sel_one, sel_any;
  logic [CREDIT_W-1:0] coin_val, price;
  logic [CREDIT_W:0]   sum;

  assign coin_any = |coin_i;
  assign sel_any  = |sel_i;
  assign coin_one = $onehot(coin_i);
  assign sel_one  = $onehot(sel_i);

  // One-hot selects make a masked OR equivalent to an indexed lookup.
  always_comb begin
    coin_val = '0;
    for (int i = 0; i < NCOIN; i++)
      if (coin_i[i]) coin_val = coin_val | COIN_VALS[i*CREDIT_W +: CREDIT_W];
    price = '0;
    for (int k = 0; k < NPROD; k++)
      if (sel_i[k]) price = price | PRICES[k*CREDIT_W +: CREDIT_W];
  end

  // Extra carry bit flags a coin that would overflow the credit register.
  assign sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      credit_q     <= '0;
      dispense_q   <= '0;
      change_val_q <= '0;
      change_vld_q <= 1'b0;
      coin_rej_q   <= 1'b0;
      status_q     <= '0;
    end else begin
      dispense_q   <= '0;
      change_val_q <= '0;
      change_vld_q <= 1'b0;
      coin_rej_q   <= 1'b0;
      status_q     <= '0;
      case (state_q)
        IDLE, ACCUM: begin
          if (cancel_i) begin
            coin_rej_q <= coin_any;
            if (state_q == ACCUM) begin
              state_q      <= CHANGE;
              change_vld_q <= 1'b1;
              change_val_q <= credit_q;
            end
          end else begin
            if (sel_any && !sel_one) status_q[ERR] <= 1'b1;
            if (coin_any && !coin_one) begin
              status_q[ERR] <= 1'b1;
              coin_rej_q    <= 1'b1;
            end
            if (sel_one) begin
              if (coin_any) coin_rej_q <= 1'b1;
              if (credit_q >= price) begin
                state_q       <= VEND;
                credit_q      <= credit_q - price;
                dispense_q    <= sel_i;
                status_q[OK]  <= 1'b1;
              end else begin
                status_q[SHORT] <= 1'b1;
              end
            end else if (coin_one) begin
              if (sum[CREDIT_W]) begin
                coin_rej_q <= 1'b1;
              end else begin
                credit_q <= sum[CREDIT_W-1:0];
                state_q  <= ACCUM;
              end
            end
          end
        end
        VEND: begin
          coin_rej_q <= coin_any;
          if (credit_q != '0) begin
            state_q      <= CHANGE;
            change_vld_q <= 1'b1;
            change_val_q <= credit_q;
          end else begin
            state_q <= IDLE;
          end
        end
        CHANGE: begin
          coin_rej_q <= coin_any;
          credit_q   <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dispense_o   = dispense_q;
  assign change_val_o = change_val_q;
  assign change_vld_o = change_vld_q;
  assign credit_o     = credit_q;
  assign coin_rej_o   = coin_rej_q;
  assign status_o     = status_q;

endmodule
